// File: rtl/rtc3w_slave_model.sv
// DS1302-style 3-wire RTC slave model: synchronised CE/SCLK/DATA decode, register file, WP rule, log and host ports.
// Optional burst mode (ADDR=5'h1F streams through regs with wrap) is enabled by defining RTC3W_BURST_EN.
module rtc3w_slave_model #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WP_ADDR     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       sclk,
  input  logic       data_i,
  output logic       data_o,
  output logic       data_oe,
  input  logic       host_we,
  input  logic [4:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       log_valid,
  output logic       log_rd,
  output logic [4:0] log_addr,
  output logic [7:0] log_data,
  output logic       log_err
);

  localparam logic [4:0] NR_A   = 5'(NUM_REGS);
  localparam logic [4:0] LAST_A = 5'(NUM_REGS - 1);
  localparam logic [4:0] WP_A   = 5'(WP_ADDR);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  logic [NUM_REGS-1:0][7:0] regs;

  logic [SYNC_STAGES-1:0] ce_sync, sclk_sync, din_sync;
  logic ce_s, sclk_s, din_s, sclk_d;
  logic s_rise, s_fall;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] rbyte_q, rbyte_d;
  logic       burst_q, burst_d;
  logic       data_o_d, data_oe_d;
  logic       log_valid_d, log_rd_d, log_err_d;
  logic [4:0] log_addr_d;
  logic [7:0] log_data_d;

  logic       ser_we;
  logic [4:0] ser_addr;
  logic [7:0] ser_wdata;
  logic [7:0] byte_in, wp_byte, cmd_rdata, next_rdata;
  logic [4:0] next_idx;
  logic       wp, commit;

  function automatic logic [7:0] reg_at(input logic [NUM_REGS-1:0][7:0] r, input logic [4:0] a);
    logic [7:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (a == 5'(i)) v = r[i];
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_sync   <= '0;
      sclk_sync <= '0;
      din_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      ce_sync   <= {ce_sync[SYNC_STAGES-2:0], ce};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], data_i};
      sclk_d    <= sclk_s;
    end
  end

  assign ce_s   = ce_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign din_s  = din_sync[SYNC_STAGES-1];
  assign s_rise = sclk_s & ~sclk_d;
  assign s_fall = ~sclk_s & sclk_d;

  always_comb begin
    byte_in    = {din_s, sh_q[7:1]};
    wp_byte    = reg_at(regs, WP_A);
    wp         = wp_byte[7];
    commit     = (addr_q < NR_A) && (!wp || (addr_q == WP_A));
    next_idx   = (addr_q == LAST_A) ? 5'd0 : addr_q + 5'd1;
    cmd_rdata  = reg_at(regs, byte_in[5:1]);
    next_rdata = reg_at(regs, next_idx);
    host_rdata = reg_at(regs, host_addr);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    addr_d      = addr_q;
    rbyte_d     = rbyte_q;
    burst_d     = burst_q;
    data_o_d    = data_o;
    data_oe_d   = data_oe;
    log_valid_d = 1'b0;
    log_rd_d    = 1'b0;
    log_addr_d  = '0;
    log_data_d  = '0;
    log_err_d   = 1'b0;
    ser_we      = 1'b0;
    ser_addr    = addr_q;
    ser_wdata   = byte_in;

    case (state_q)
      ST_IDLE: begin
        if (ce_s) begin
          state_d   = ST_CMD;
          cnt_d     = '0;
          burst_d   = 1'b0;
          data_o_d  = 1'b0;
          data_oe_d = 1'b0;
        end
      end
      ST_CMD: begin
        if (s_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (!byte_in[7]) begin
              log_err_d = 1'b1;
              state_d   = ST_IGNORE;
            end else begin
              addr_d  = byte_in[5:1];
              burst_d = 1'b0;
              rbyte_d = cmd_rdata;
`ifdef RTC3W_BURST_EN
              if (byte_in[5:1] == 5'h1F) begin
                addr_d  = '0;
                burst_d = 1'b1;
                rbyte_d = reg_at(regs, 5'd0);
              end
`endif
              sh_d    = rbyte_d;
              state_d = byte_in[0] ? ST_RDATA : ST_WDATA;
            end
          end
        end
      end
      ST_WDATA: begin
        if (s_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            ser_we      = commit;
            log_valid_d = 1'b1;
            log_addr_d  = addr_q;
            log_data_d  = byte_in;
            log_err_d   = !commit;
            if (burst_q) addr_d = next_idx;
            else         state_d = ST_IGNORE;
          end
        end
      end
      ST_RDATA: begin
        if (s_fall) begin
          data_oe_d = 1'b1;
          data_o_d  = sh_q[0];
          sh_d      = {1'b0, sh_q[7:1]};
        end
        // The byte completes on the master's sampling edge; a burst reloads here so the
        // next falling edge already presents bit 0 of the following register.
        if (s_rise) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            log_valid_d = 1'b1;
            log_rd_d    = 1'b1;
            log_addr_d  = addr_q;
            log_data_d  = rbyte_q;
            if (burst_q) begin
              addr_d  = next_idx;
              sh_d    = next_rdata;
              rbyte_d = next_rdata;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
      end
      ST_IGNORE: ;
      default: state_d = ST_IDLE;
    endcase

    if (!ce_s) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      burst_d     = 1'b0;
      data_o_d    = 1'b0;
      data_oe_d   = 1'b0;
      ser_we      = 1'b0;
      log_valid_d = 1'b0;
      log_rd_d    = 1'b0;
      log_addr_d  = '0;
      log_data_d  = '0;
      log_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      addr_q    <= '0;
      rbyte_q   <= '0;
      burst_q   <= 1'b0;
      data_o    <= 1'b0;
      data_oe   <= 1'b0;
      log_valid <= 1'b0;
      log_rd    <= 1'b0;
      log_addr  <= '0;
      log_data  <= '0;
      log_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      rbyte_q   <= rbyte_d;
      burst_q   <= burst_d;
      data_o    <= data_o_d;
      data_oe   <= data_oe_d;
      log_valid <= log_valid_d;
      log_rd    <= log_rd_d;
      log_addr  <= log_addr_d;
      log_data  <= log_data_d;
      log_err   <= log_err_d;
    end
  end

  // Serial commit is applied after the host write so it wins on an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (host_we && (host_addr == 5'(i))) regs[i] <= host_wdata;
        if (ser_we && (ser_addr == 5'(i)))   regs[i] <= ser_wdata;
      end
    end
  end

endmodule

// File: doc/rtc3w_slave_model.md
Name: rtc3w_slave_model

Overview:
- Synthesizable, parametrised model of a DS1302-style 3-wire RTC slave (CE/SCLK/DATA) with a register file.
- Placed in simulation, or on a spare FPGA, opposite the clock design's RTC master.
- Replaces ad-hoc SCLK sampling in benches: decodes every transaction, applies the write-protect rule, reports each completed byte on a log port, and exposes a host port for preload and inspection.

Parameters:
- NUM_REGS, 8: implemented registers at addresses 0..NUM_REGS-1; legal range 1..31.
- SYNC_STAGES, 2: synchroniser depth on CE, SCLK and data_i; legal values 2..4.
- WP_ADDR, 7: address of the control register; its bit 7 is WP.

Ports:
- clk  in  1  system clock; must be ≥8x the SCLK frequency.
- rst  in  1  asynchronous reset, active-low.
- ce  in  1  3-wire chip enable from the master.
- sclk  in  1  3-wire serial clock from the master.
- data_i  in  1  DATA line as seen by the slave.
- data_o  out  1  slave drive value.
- data_oe  out  1  slave drive enable; the top level builds the tri-state.
- host_we  in  1  host write strobe.
- host_addr  in  5  host register address.
- host_wdata  in  8  host write data.
- host_rdata  out  8  regs[host_addr], combinational; 0 when host_addr ≥ NUM_REGS.
- log_valid  out  1  one-cycle pulse per completed data byte.
- log_rd  out  1  1 = read byte, 0 = write byte.
- log_addr  out  5  register address of the logged byte.
- log_data  out  8  byte transferred.
- log_err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset (rst=0): all registers 0; FSM in IDLE; data_o=0, data_oe=0; all log outputs 0.
- Input conditioning: ce, sclk and data_i pass through SYNC_STAGES flops. Edge detect on synchronised sclk gives s_rise and s_fall, each one clk wide.
- IDLE: leave when synced CE=1 → CMD with bit counter 0.
- CMD: shift data_i in LSB first on each s_rise. After the 8th bit, cmd[0]=RD, cmd[5:1]=ADDR, cmd[7] must be 1.
  - cmd[7]=0 → log_err pulse, go to IGNORE.
  - RD=1 → RDATA, with shift register loaded from regs[ADDR], or 0 when ADDR ≥ NUM_REGS.
  - RD=0 → WDATA.
- WDATA: 8 data bits LSB first on s_rise. On the 8th bit:
  - Write commits unless ADDR ≥ NUM_REGS, or WP=1 and ADDR ≠ WP_ADDR. The WP_ADDR register is always writable.
  - log_valid=1, log_rd=0, log_data = received byte, whether or not the write committed.
  - log_err=1 when the write is discarded.
  - Then go to IGNORE, or stay in the burst path.
- RDATA:
  - On each s_fall, data_oe=1 and data_o = next bit, LSB first. The first bit goes out on the s_fall that follows the 8th command s_rise.
  - The 8th data s_rise completes the byte: log_valid=1, log_rd=1; data_oe stays 1 until CE drops.
- IGNORE: hold until CE=0.
- CE=0 in any state (synchronised): FSM returns to IDLE the next cycle; data_oe=0; partial bytes are discarded with no log entry.
- Simultaneous host_we and serial commit to the same address in the same cycle: the serial write wins.
- Host writes bypass WP.
- host_we and host writes are accepted in every state.
- Asserting rst mid-transaction clears everything immediately, with no log entry.
- Latency: log_valid asserts 1 clk after the synchronised 8th-data s_rise. Total is SYNC_STAGES+2 clk after the pin edge.

Optional Feature:
- Macro: RTC3W_BURST_EN.
- Defined: ADDR=5'h1F selects burst mode.
  - Data bytes stream to or from regs[0], regs[1], … with an auto-incrementing index, until CE=0.
  - The index wraps to 0 after NUM_REGS-1.
  - Each byte is logged with log_addr = actual index.
  - A burst write with WP=1 discards every byte except the one at WP_ADDR, pulsing log_err per discarded byte.
- Undefined: 5'h1F is an ordinary out-of-range address. Reads return 0; writes are discarded with log_err.

Test Plan:
- Reset → data_oe=0, log_valid=0, host_rdata=0 at every address; release rst and idle 100 clk → no log activity.
- Serial write cmd 8'h80 then data 8'h59 (WP=0) → regs[0]=8'h59; one log_valid with log_rd=0, log_addr=0, log_data=8'h59.
- Host preload regs[2]=8'h23, then serial read cmd 8'h85 → data_o bits LSB first on falling SCLK give 8'h23; log_rd=1, log_addr=2.
- Host writes regs[7]=8'h80 (WP=1), then serial write 8'h11 to addr 1 → regs[1] unchanged, log_err=1. Then write 8'h00 to addr 7 → WP cleared.
- Command byte 8'h02 (bit7=0) → log_err pulse, no writes, data_oe=0 until CE drops. CE dropped after 4 data bits → no log, FSM in IDLE.
- With RTC3W_BURST_EN defined: burst read cmd 8'hBF with NUM_REGS=8 and 9 bytes clocked → bytes regs[0..7] then regs[0]; log_addr sequence 0..7, 0.
